// File: rtl/qsys_onchip_mem_dp.sv
// Dual-port Avalon-MM on-chip memory: two independent slaves (s1, s2) over one shared array.
// Fixed read latency of 1 or 2 cycles with readdatavalid, per-lane s1-wins write collisions,
// old-data read-during-write and zero-returning out-of-range reads.
module qsys_onchip_mem_dp #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ENABLE_S2    = 1,
  parameter string       INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int unsigned NumLanes = DATA_WIDTH / 8;
  localparam logic HasS2 = (ENABLE_S2 != 0);
  localparam logic [ADDR_WIDTH:0] DepthLimit = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  en;
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [NumLanes-1:0]   be     [2];
  logic [DATA_WIDTH-1:0] wdata  [2];
  logic [NumLanes-1:0]   wr_be  [2];
  logic [1:0]            rd_acc;
  logic [1:0]            wr_acc;
  logic [1:0]            in_range;

  logic [DATA_WIDTH-1:0] mem    [DEPTH];
  logic [DATA_WIDTH-1:0] raw_q  [2];
  logic [DATA_WIDTH-1:0] d2_q   [2];
  logic [DATA_WIDTH-1:0] rdata  [2];
  logic [1:0]            v1_q;
  logic [1:0]            v2_q;
  logic [1:0]            ok_q;

  assign en = clken & ~reset_req;

  // Decode accepted accesses and merge colliding writes so s1 owns any lane both ports hit.
  always_comb begin
    addr[0]     = s1_address;
    be[0]       = s1_byteenable;
    wdata[0]    = s1_writedata;
    rd_acc[0]   = s1_chipselect & s1_read & en;
    wr_acc[0]   = s1_chipselect & s1_write & en;
    addr[1]     = s2_address;
    be[1]       = s2_byteenable;
    wdata[1]    = s2_writedata;
    rd_acc[1]   = HasS2 & s2_chipselect & s2_read & en;
    wr_acc[1]   = HasS2 & s2_chipselect & s2_write & en;
    in_range[0] = {1'b0, addr[0]} < DepthLimit;
    in_range[1] = {1'b0, addr[1]} < DepthLimit;
    wr_be[0]    = (wr_acc[0] && in_range[0]) ? be[0] : '0;
    wr_be[1]    = (wr_acc[1] && in_range[1]) ? be[1] : '0;
    if (addr[0] == addr[1]) begin
      wr_be[1] = wr_be[1] & ~wr_be[0];
    end
  end

  // Array ports: lane writes plus registered reads; the read samples pre-write contents.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int l = 0; l < int'(NumLanes); l++) begin
        if (wr_be[p][l]) begin
          mem[addr[p]][l*8 +: 8] <= wdata[p][l*8 +: 8];
        end
      end
      if (rd_acc[p]) begin
        raw_q[p] <= in_range[p] ? mem[addr[p]] : '0;
      end
    end
  end

  // Read pipeline control and optional output register; frozen on cycles with en low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= '0;
      v2_q    <= '0;
      ok_q    <= '0;
      d2_q[0] <= '0;
      d2_q[1] <= '0;
    end else if (en) begin
      v1_q <= rd_acc;
      v2_q <= v1_q;
      // ok_q masks the unreset array register until a read has landed since reset.
      ok_q <= ok_q | rd_acc;
      for (int p = 0; p < 2; p++) begin
        if (v1_q[p]) begin
          d2_q[p] <= raw_q[p];
        end
      end
    end
  end

  // Select the output stage for the configured latency; a disabled s2 drives zeros.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = (READ_LATENCY == 2) ? d2_q[p] : (ok_q[p] ? raw_q[p] : '0);
    end
    s1_readdata      = rdata[0];
    s1_readdatavalid = (READ_LATENCY == 2) ? v2_q[0] : v1_q[0];
    s2_readdata      = HasS2 ? rdata[1] : '0;
    s2_readdatavalid = HasS2 & ((READ_LATENCY == 2) ? v2_q[1] : v1_q[1]);
  end

endmodule

// File: tb/tb_qsys_onchip_mem_dp.sv
// Bench for qsys_onchip_mem_dp: a latency-1 and a latency-2 instance (DEPTH=1000) share one
// stimulus table; expected read data is queued at accept and compared when readdatavalid fires.
module tb_qsys_onchip_mem_dp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned BW = 4;

  logic          clk = 1'b0;
  logic          reset, reset_req, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [BW-1:0] s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata;
  // Index k = instance*2 + port; instance 0 has latency 1, instance 1 latency 2.
  logic [DW-1:0] rdata [4];
  logic          valid [4];

  always #5 clk = ~clk;

  qsys_onchip_mem_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1000), .READ_LATENCY(1), .ENABLE_S2(1), .INIT_FILE("")
  ) u_dut_l1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(rdata[0]), .s1_readdatavalid(valid[0]),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(rdata[1]), .s2_readdatavalid(valid[1])
  );

  qsys_onchip_mem_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1000), .READ_LATENCY(2), .ENABLE_S2(1), .INIT_FILE("")
  ) u_dut_l2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(rdata[2]), .s1_readdatavalid(valid[2]),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(rdata[3]), .s2_readdatavalid(valid[3])
  );

  typedef struct {
    bit c, rq;
    bit w1, r1; logic [AW-1:0] a1; logic [BW-1:0] be1; logic [DW-1:0] d1, x1;
    bit w2, r2; logic [AW-1:0] a2; logic [BW-1:0] be2; logic [DW-1:0] d2, x2;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   stamp;
  } exp_t;

  vec_t        vecs [$];
  exp_t        sb_q [4][$];
  logic [DW-1:0] prev_d [4];
  logic          prev_v [4];
  int unsigned en_cnt = 0;
  int          tests = 0;
  int          fails = 0;

  function automatic vec_t row(input bit c, rq, w1, r1, input logic [AW-1:0] a1,
                               input logic [BW-1:0] be1, input logic [DW-1:0] d1, x1,
                               input bit w2, r2, input logic [AW-1:0] a2,
                               input logic [BW-1:0] be2, input logic [DW-1:0] d2, x2);
    vec_t v;
    v.c = c; v.rq = rq;
    v.w1 = w1; v.r1 = r1; v.a1 = a1; v.be1 = be1; v.d1 = d1; v.x1 = x1;
    v.w2 = w2; v.r2 = r2; v.a2 = a2; v.be2 = be2; v.d2 = d2; v.x2 = x2;
    return v;
  endfunction

  function automatic vec_t idle();
    return row(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 32'h0,
               1'b0, 1'b0, 10'd0, 4'h0, 32'h0, 32'h0);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    clken = v.c; reset_req = v.rq;
    s1_chipselect = v.w1 | v.r1; s1_write = v.w1; s1_read = v.r1;
    s1_address = v.a1; s1_byteenable = v.be1; s1_writedata = v.d1;
    s2_chipselect = v.w2 | v.r2; s2_write = v.w2; s2_read = v.r2;
    s2_address = v.a2; s2_byteenable = v.be2; s2_writedata = v.d2;
  endtask

  task automatic monitor(input bit enabled);
    exp_t e;
    int unsigned lat;
    for (int k = 0; k < 4; k++) begin
      lat = (k >= 2) ? 2 : 1;
      if (!enabled) begin
        chk($sformatf("stall_hold_valid%0d", k), {31'b0, valid[k]}, {31'b0, prev_v[k]});
        chk($sformatf("stall_hold_data%0d", k), rdata[k], prev_d[k]);
      end else if (valid[k]) begin
        if (sb_q[k].size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid%0d: got valid with data %h, required no valid",
                   k, rdata[k]);
        end else begin
          e = sb_q[k].pop_front();
          chk($sformatf("read_data%0d", k), rdata[k], e.data);
          chk($sformatf("read_latency%0d", k), en_cnt - e.stamp + 1, lat);
        end
      end else if (sb_q[k].size() != 0) begin
        e = sb_q[k][0];
        if (en_cnt - e.stamp + 1 >= lat) begin
          tests++; fails++;
          $display("FAIL missing_valid%0d: got no valid, required data %h", k, e.data);
          void'(sb_q[k].pop_front());
        end
      end
      prev_v[k] = valid[k];
      prev_d[k] = rdata[k];
    end
  endtask

  task automatic step(input vec_t v, input bit mon);
    bit en;
    exp_t e;
    drive(v);
    @(posedge clk);
    en = v.c & ~v.rq;
    if (en) en_cnt++;
    if (en && v.r1) begin
      e.data = v.x1; e.stamp = en_cnt;
      sb_q[0].push_back(e); sb_q[2].push_back(e);
    end
    if (en && v.r2) begin
      e.data = v.x2; e.stamp = en_cnt;
      sb_q[1].push_back(e); sb_q[3].push_back(e);
    end
    if (mon) begin
      @(negedge clk);
      monitor(en);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, required finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rd20;
    // c rq | w1 r1 a1 be1 d1 x1 | w2 r2 a2 be2 d2 x2
    vecs.push_back(row(1, 0, 1, 0, 10'd5, 4'hF, 32'hDEADBEEF, 32'h0,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 0, 1, 10'd5, 4'h0, 32'h0, 32'hDEADBEEF,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 0, 0, 10'd0, 4'h0, 32'h0, 32'h0,
                       0, 1, 10'd5, 4'h0, 32'h0, 32'hDEADBEEF));
    vecs.push_back(row(1, 0, 1, 0, 10'd7, 4'hF, 32'h11223344, 32'h0,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 0, 0, 10'd0, 4'h0, 32'h0, 32'h0,
                       1, 0, 10'd7, 4'h5, 32'hAABBCCDD, 32'h0));
    vecs.push_back(row(1, 0, 0, 1, 10'd7, 4'h0, 32'h0, 32'h11BB33DD,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 1, 0, 10'd3, 4'h1, 32'h000000FF, 32'h0,
                       1, 0, 10'd3, 4'hF, 32'h12345678, 32'h0));
    vecs.push_back(row(1, 0, 0, 1, 10'd3, 4'h0, 32'h0, 32'h123456FF,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 1, 0, 10'd3, 4'hF, 32'h0, 32'h0,
                       0, 1, 10'd3, 4'h0, 32'h0, 32'h123456FF));
    vecs.push_back(row(1, 0, 0, 0, 10'd0, 4'h0, 32'h0, 32'h0,
                       0, 1, 10'd3, 4'hF, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 1, 1, 10'd5, 4'hF, 32'h01020304, 32'hDEADBEEF,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 0, 1, 10'd5, 4'h0, 32'h0, 32'h01020304,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 1, 0, 10'd0, 4'hF, 32'hA0A0A0A0, 32'h0,
                       1, 0, 10'd1, 4'hF, 32'hB1B1B1B1, 32'h0));
    vecs.push_back(row(1, 0, 1, 0, 10'd2, 4'hF, 32'hC2C2C2C2, 32'h0,
                       1, 0, 10'd3, 4'hF, 32'hD3D3D3D3, 32'h0));
    vecs.push_back(row(1, 0, 1, 0, 10'd10, 4'hF, 32'h10101010, 32'h0,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 0, 1, 10'd0, 4'h0, 32'h0, 32'hA0A0A0A0,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 0, 1, 10'd1, 4'h0, 32'h0, 32'hB1B1B1B1,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(0, 0, 0, 1, 10'd2, 4'h0, 32'h0, 32'hC2C2C2C2,
                       1, 0, 10'd2, 4'hF, 32'hFFFFFFFF, 32'h0));
    vecs.push_back(row(1, 1, 0, 1, 10'd2, 4'h0, 32'h0, 32'hC2C2C2C2,
                       1, 0, 10'd2, 4'hF, 32'hFFFFFFFF, 32'h0));
    vecs.push_back(row(1, 0, 0, 1, 10'd2, 4'h0, 32'h0, 32'hC2C2C2C2,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 0, 1, 10'd3, 4'h0, 32'h0, 32'hD3D3D3D3,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(idle());
    vecs.push_back(row(1, 0, 0, 0, 10'd0, 4'h0, 32'h0, 32'h0,
                       0, 1, 10'd2, 4'h0, 32'h0, 32'hC2C2C2C2));
    vecs.push_back(row(1, 0, 1, 0, 10'd1010, 4'hF, 32'hCAFEF00D, 32'h0,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 0, 1, 10'd1010, 4'h0, 32'h0, 32'h00000000,
                       0, 1, 10'd10, 4'h0, 32'h0, 32'h10101010));
    vecs.push_back(row(1, 0, 1, 0, 10'd5, 4'h0, 32'hFFFFFFFF, 32'h0,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    vecs.push_back(row(1, 0, 0, 1, 10'd5, 4'h0, 32'h0, 32'h01020304,
                       0, 0, 10'd0, 4'h0, 32'h0, 32'h0));
    repeat (3) vecs.push_back(idle());

    reset = 1'b1;
    drive(idle());
    for (int k = 0; k < 4; k++) begin
      prev_v[k] = 1'b0;
      prev_d[k] = '0;
    end
    #3;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_valid%0d", k), {31'b0, valid[k]}, 32'h0);
      chk($sformatf("reset_data%0d", k), rdata[k], 32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], 1'b1);
    end

    // Reset lands between a read accept and its data; nothing may surface afterwards.
    step(row(1, 0, 1, 0, 10'd20, 4'hF, 32'h5A5A5A5A, 32'h0,
             0, 0, 10'd0, 4'h0, 32'h0, 32'h0), 1'b1);
    step(idle(), 1'b1);
    rd20 = row(1, 0, 0, 1, 10'd20, 4'h0, 32'h0, 32'h5A5A5A5A,
               0, 1, 10'd20, 4'h0, 32'h0, 32'h5A5A5A5A);
    step(rd20, 1'b0);
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("midrst_valid%0d", k), {31'b0, valid[k]}, 32'h0);
      chk($sformatf("midrst_data%0d", k), rdata[k], 32'h0);
      sb_q[k].delete();
      prev_v[k] = 1'b0;
      prev_d[k] = '0;
    end
    drive(idle());
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) step(idle(), 1'b1);
    step(rd20, 1'b1);
    repeat (3) step(idle(), 1'b1);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), sb_q[k].size(), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
